// File: rtl/dmem_arb.sv
// Two-CPU round-robin arbiter in front of a single-port line memory (d_mem).
// One transaction at a time: latch request in IDLE, drive memory in BUSY, pulse rdy in DONE.
module dmem_arb #(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu0_re,
    input  logic        cpu0_we,
    input  logic [10:0] cpu0_addr,
    input  logic [63:0] cpu0_wline,
    output logic        cpu0_rdy,
    output logic [63:0] cpu0_rline,

    input  logic        cpu1_re,
    input  logic        cpu1_we,
    input  logic [10:0] cpu1_addr,
    input  logic [63:0] cpu1_wline,
    output logic        cpu1_rdy,
    output logic [63:0] cpu1_rline,

    output logic        mem_re,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [63:0] mem_wline,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rdy,

    output logic        grant_0,
    output logic        grant_1,
    output logic        err
);

    localparam int unsigned CNT_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_id, w_id_nxt;
    logic               r_we, w_we_nxt;
    logic [10:0]        r_addr, w_addr_nxt;
    logic [63:0]        r_wline, w_wline_nxt;
    logic               r_last, w_last_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_err, w_err_nxt;
    logic [63:0]        r_rline0, w_rline0_nxt;
    logic [63:0]        r_rline1, w_rline1_nxt;

    logic               w_req0, w_req1, w_pick1, w_both;

    assign w_req0  = cpu0_re | cpu0_we;
    assign w_req1  = cpu1_re | cpu1_we;
    // r_last holds the id granted most recently; on contention the other CPU wins.
    assign w_pick1 = w_req1 & (~w_req0 | ~r_last);
    assign w_both  = w_pick1 ? (cpu1_re & cpu1_we) : (cpu0_re & cpu0_we);

    always_comb begin
        w_state_nxt  = r_state;
        w_id_nxt     = r_id;
        w_we_nxt     = r_we;
        w_addr_nxt   = r_addr;
        w_wline_nxt  = r_wline;
        w_last_nxt   = r_last;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
        w_rline0_nxt = r_rline0;
        w_rline1_nxt = r_rline1;

        unique case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                if (w_req0 || w_req1) begin
                    w_state_nxt = StBusy;
                    w_id_nxt    = w_pick1;
                    w_last_nxt  = w_pick1;
                    w_we_nxt    = w_pick1 ? cpu1_we    : cpu0_we;
                    w_addr_nxt  = w_pick1 ? cpu1_addr  : cpu0_addr;
                    w_wline_nxt = w_pick1 ? cpu1_wline : cpu0_wline;
                    if (w_both) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (mem_rdy) begin
                    w_state_nxt = StDone;
                    if (!r_we) begin
                        if (r_id) begin
                            w_rline1_nxt = mem_rdata;
                        end else begin
                            w_rline0_nxt = mem_rdata;
                        end
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = StDone;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_id     <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wline  <= '0;
            r_last   <= 1'b1;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_rline0 <= '0;
            r_rline1 <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_id     <= w_id_nxt;
            r_we     <= w_we_nxt;
            r_addr   <= w_addr_nxt;
            r_wline  <= w_wline_nxt;
            r_last   <= w_last_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            r_rline0 <= w_rline0_nxt;
            r_rline1 <= w_rline1_nxt;
        end
    end

    // Grant derives from the latched owner, so it is one-hot by construction.
    assign grant_0    = (r_state != StIdle) && !r_id;
    assign grant_1    = (r_state != StIdle) &&  r_id;
    assign mem_re     = (r_state == StBusy) && !r_we;
    assign mem_we     = (r_state == StBusy) &&  r_we;
    assign mem_addr   = r_addr;
    assign mem_wline  = r_wline;
    assign cpu0_rdy   = (r_state == StDone) && !r_id;
    assign cpu1_rdy   = (r_state == StDone) &&  r_id;
    assign cpu0_rline = r_rline0;
    assign cpu1_rline = r_rline1;
    assign err        = r_err;

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb (TMO_CYC=4); outputs sampled 1 time unit after each rising edge.
module tb_dmem_arb;

    logic        clk;
    logic        rst;
    logic        cpu0_re, cpu0_we, cpu1_re, cpu1_we;
    logic [10:0] cpu0_addr, cpu1_addr;
    logic [63:0] cpu0_wline, cpu1_wline;
    logic        cpu0_rdy, cpu1_rdy;
    logic [63:0] cpu0_rline, cpu1_rline;
    logic        mem_re, mem_we;
    logic [10:0] mem_addr;
    logic [63:0] mem_wline, mem_rdata;
    logic        mem_rdy;
    logic        grant_0, grant_1, err;

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [63:0] LineT1 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] LineA  = 64'h0000_0000_AAAA_0001;
    localparam logic [63:0] LineB  = 64'h0000_0000_BBBB_0002;
    localparam logic [63:0] LineC  = 64'h0000_0000_CCCC_0003;
    localparam logic [63:0] LineD  = 64'h0000_0000_DDDD_0004;
    localparam logic [63:0] LineE  = 64'hEEEE_0000_0000_0005;

    dmem_arb #(
        .TMO_CYC(4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cpu0_re    (cpu0_re),
        .cpu0_we    (cpu0_we),
        .cpu0_addr  (cpu0_addr),
        .cpu0_wline (cpu0_wline),
        .cpu0_rdy   (cpu0_rdy),
        .cpu0_rline (cpu0_rline),
        .cpu1_re    (cpu1_re),
        .cpu1_we    (cpu1_we),
        .cpu1_addr  (cpu1_addr),
        .cpu1_wline (cpu1_wline),
        .cpu1_rdy   (cpu1_rdy),
        .cpu1_rline (cpu1_rline),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wline  (mem_wline),
        .mem_rdata  (mem_rdata),
        .mem_rdy    (mem_rdy),
        .grant_0    (grant_0),
        .grant_1    (grant_1),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; mutual-exclusion properties are checked every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        check_eq("grant_onehot", {63'd0, grant_0 & grant_1}, 64'd0);
        check_eq("mem_strobe_excl", {63'd0, mem_re & mem_we}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cpu0_re = 1'b0; cpu0_we = 1'b0; cpu0_addr = '0; cpu0_wline = '0;
        cpu1_re = 1'b0; cpu1_we = 1'b0; cpu1_addr = '0; cpu1_wline = '0;
        mem_rdata = '0; mem_rdy = 1'b0;
        tick();
        tick();
        check_eq("rst_grant0", grant_0, 0);
        check_eq("rst_grant1", grant_1, 0);
        check_eq("rst_mem_re", mem_re, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_rdy0", cpu0_rdy, 0);
        check_eq("rst_rdy1", cpu1_rdy, 0);
        check_eq("rst_rline0", cpu0_rline, 0);
        check_eq("rst_rline1", cpu1_rline, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wline", mem_wline, 0);
        rst = 1'b0;

        // CPU0 read, mem_rdy three cycles after the first strobe cycle
        cpu0_re = 1'b1; cpu0_addr = 11'h012;
        tick();
        check_eq("t1_mem_re", mem_re, 1);
        check_eq("t1_mem_addr", mem_addr, 11'h012);
        check_eq("t1_grant0", grant_0, 1);
        check_eq("t1_rdy_early", cpu0_rdy, 0);
        tick();
        check_eq("t1_mem_re_hold", mem_re, 1);
        tick();
        tick();
        mem_rdy = 1'b1; mem_rdata = LineT1;
        check_eq("t1_rdy_before", cpu0_rdy, 0);
        tick();
        check_eq("t1_rdy", cpu0_rdy, 1);
        check_eq("t1_rline", cpu0_rline, LineT1);
        check_eq("t1_mem_re_done", mem_re, 0);
        check_eq("t1_grant0_done", grant_0, 1);
        cpu0_re = 1'b0; mem_rdy = 1'b0;
        tick();
        check_eq("t1_rdy_after", cpu0_rdy, 0);
        check_eq("t1_grant0_idle", grant_0, 0);

        // Simultaneous requests after reset; CPU0 then re-requests against pending CPU1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu0_re = 1'b1; cpu0_addr = 11'h100;
        cpu1_re = 1'b1; cpu1_addr = 11'h200;
        tick();
        check_eq("t2_grant0", grant_0, 1);
        check_eq("t2_grant1", grant_1, 0);
        check_eq("t2_addr0", mem_addr, 11'h100);
        mem_rdy = 1'b1; mem_rdata = LineA;
        tick();
        check_eq("t2_rdy0", cpu0_rdy, 1);
        check_eq("t2_rdy1_wait", cpu1_rdy, 0);
        check_eq("t2_rline0", cpu0_rline, LineA);
        mem_rdy = 1'b0; cpu0_addr = 11'h101;
        tick();
        check_eq("t2_idle_grant1", grant_1, 0);
        check_eq("t2_idle_rdy0", cpu0_rdy, 0);
        tick();
        check_eq("t2_rr_grant1", grant_1, 1);
        check_eq("t2_rr_grant0", grant_0, 0);
        check_eq("t2_addr1", mem_addr, 11'h200);
        mem_rdy = 1'b1; mem_rdata = LineB;
        tick();
        check_eq("t2_rdy1", cpu1_rdy, 1);
        check_eq("t2_rdy0_wait", cpu0_rdy, 0);
        check_eq("t2_rline1", cpu1_rline, LineB);
        check_eq("t2_rline0_keep", cpu0_rline, LineA);
        cpu1_re = 1'b0; mem_rdy = 1'b0;
        tick();
        tick();
        check_eq("t2_grant0_again", grant_0, 1);
        check_eq("t2_addr0_again", mem_addr, 11'h101);
        mem_rdy = 1'b1; mem_rdata = LineC;
        tick();
        check_eq("t2_rdy0_again", cpu0_rdy, 1);
        check_eq("t2_rline0_again", cpu0_rline, LineC);
        cpu0_re = 1'b0; mem_rdy = 1'b0;
        tick();

        // CPU1 write; request changes mid-BUSY must not disturb the latched copy
        cpu1_we = 1'b1; cpu1_addr = 11'h7FF; cpu1_wline = 64'h1;
        tick();
        check_eq("t3_mem_we", mem_we, 1);
        check_eq("t3_mem_re", mem_re, 0);
        check_eq("t3_addr", mem_addr, 11'h7FF);
        check_eq("t3_wline", mem_wline, 64'h1);
        check_eq("t3_grant1", grant_1, 1);
        cpu1_addr = 11'h000; cpu1_wline = 64'hFF;
        tick();
        check_eq("t3_we_hold", mem_we, 1);
        check_eq("t3_addr_hold", mem_addr, 11'h7FF);
        check_eq("t3_wline_hold", mem_wline, 64'h1);
        check_eq("t3_rdy_early", cpu1_rdy, 0);
        mem_rdy = 1'b1; mem_rdata = 64'h5555;
        tick();
        check_eq("t3_rdy1", cpu1_rdy, 1);
        check_eq("t3_rline1_keep", cpu1_rline, LineB);
        check_eq("t3_we_done", mem_we, 0);
        cpu1_we = 1'b0; mem_rdy = 1'b0;
        tick();
        check_eq("t3_err", err, 0);

        // Stray mem_rdy in IDLE, then a timeout with TMO_CYC=4
        mem_rdy = 1'b1;
        tick();
        check_eq("t4_stray_g0", grant_0, 0);
        check_eq("t4_stray_g1", grant_1, 0);
        check_eq("t4_stray_rdy0", cpu0_rdy, 0);
        check_eq("t4_stray_rdy1", cpu1_rdy, 0);
        mem_rdy = 1'b0;
        cpu0_re = 1'b1; cpu0_addr = 11'h033;
        tick();
        check_eq("t4_busy1", mem_re, 1);
        tick();
        tick();
        tick();
        check_eq("t4_busy4", mem_re, 1);
        check_eq("t4_rdy_early", cpu0_rdy, 0);
        check_eq("t4_err_early", err, 0);
        tick();
        check_eq("t4_rdy", cpu0_rdy, 1);
        check_eq("t4_err", err, 1);
        check_eq("t4_mem_re_done", mem_re, 0);
        check_eq("t4_rline_keep", cpu0_rline, LineC);
        cpu0_re = 1'b0;
        repeat (3) tick();
        check_eq("t4_err_sticky", err, 1);
        check_eq("t4_rdy_after", cpu0_rdy, 0);

        // Reset during BUSY aborts with no rdy
        cpu1_re = 1'b1; cpu1_addr = 11'h044;
        tick();
        check_eq("t5_busy", mem_re, 1);
        check_eq("t5_grant1", grant_1, 1);
        rst = 1'b1; cpu1_re = 1'b0;
        tick();
        check_eq("t5_mem_re", mem_re, 0);
        check_eq("t5_grant0", grant_0, 0);
        check_eq("t5_grant1_clr", grant_1, 0);
        check_eq("t5_rdy1", cpu1_rdy, 0);
        check_eq("t5_err_clr", err, 0);
        check_eq("t5_rline0_clr", cpu0_rline, 0);
        rst = 1'b0;
        tick();
        check_eq("t5_no_rdy1", cpu1_rdy, 0);
        check_eq("t5_no_rdy0", cpu0_rdy, 0);
        cpu0_re = 1'b1; cpu0_addr = 11'h055;
        tick();
        check_eq("t5_new_grant0", grant_0, 1);
        check_eq("t5_new_addr", mem_addr, 11'h055);
        mem_rdy = 1'b1; mem_rdata = LineD;
        tick();
        check_eq("t5_new_rdy0", cpu0_rdy, 1);
        check_eq("t5_new_rline0", cpu0_rline, LineD);
        cpu0_re = 1'b0; mem_rdy = 1'b0;
        tick();

        // re and we together: issued as a write, err set
        check_eq("t6_err_pre", err, 0);
        cpu0_re = 1'b1; cpu0_we = 1'b1; cpu0_addr = 11'h066; cpu0_wline = LineE;
        tick();
        check_eq("t6_mem_we", mem_we, 1);
        check_eq("t6_mem_re", mem_re, 0);
        check_eq("t6_addr", mem_addr, 11'h066);
        check_eq("t6_wline", mem_wline, LineE);
        check_eq("t6_err", err, 1);
        mem_rdy = 1'b1; mem_rdata = 64'h1234;
        tick();
        check_eq("t6_rdy0", cpu0_rdy, 1);
        check_eq("t6_rline_keep", cpu0_rline, LineD);
        cpu0_re = 1'b0; cpu0_we = 1'b0; mem_rdy = 1'b0;
        tick();
        check_eq("t6_err_sticky", err, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
